axi_fifo_param: RTL and testbench



---
 rtl/axi_fifo_param_pkg.sv | 7 +
 rtl/axi_fifo_param_ram.sv | 28 ++
 rtl/axi_fifo_param.sv | 89 ++++++++
 tb/tb_axi_fifo_param.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/axi_fifo_param_pkg.sv
// rtl/axi_fifo_param_pkg.sv - shared constants for the parametrised AXI-Stream FIFO
package axi_fifo_param_pkg;

    // Fixed width of the space/occupied status ports; large enough for SIZE=16.
    localparam int COUNT_W = 18;

endpackage

// File: rtl/axi_fifo_param_ram.sv
// rtl/axi_fifo_param_ram.sv - simple dual-port WIDTH x 2**SIZE storage for axi_fifo_param
module axi_fifo_param_ram #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 9
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [SIZE-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [SIZE-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:(1 << SIZE)-1];

    // Write-first read: a word written into the empty head slot is visible one edge later.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_fifo_param.sv
// rtl/axi_fifo_param.sv - AXI-Stream FIFO of 2**SIZE words, or a zero-latency wire when PASSTHRU=1
module axi_fifo_param
    import axi_fifo_param_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 9,
    parameter bit PASSTHRU = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [WIDTH-1:0]   i_tdata,
    input  logic               i_tvalid,
    output logic               i_tready,
    output logic [WIDTH-1:0]   o_tdata,
    output logic               o_tvalid,
    input  logic               o_tready,
    output logic [COUNT_W-1:0] space,
    output logic [COUNT_W-1:0] occupied
);

    localparam int                 DEPTH     = 1 << SIZE;
    localparam logic [COUNT_W-1:0] DEPTH_CNT = COUNT_W'(DEPTH);

    generate
        if (PASSTHRU) begin : g_pass
            logic unused_pass;

            assign unused_pass = ^{clk, reset, clear};
            assign o_tdata     = i_tdata;
            assign o_tvalid    = i_tvalid;
            assign i_tready    = o_tready;
            assign space       = DEPTH_CNT;
            assign occupied    = '0;
        end else begin : g_fifo
            logic [SIZE-1:0]    wr_ptr;
            logic [SIZE-1:0]    rd_ptr;
            logic [SIZE-1:0]    rd_next;
            logic [COUNT_W-1:0] count;
            logic               flush;
            logic               push;
            logic               pop;

            // Handshakes come only from registered count plus flush, never from the peer's valid/ready.
            assign flush    = reset | clear;
            assign i_tready = (count < DEPTH_CNT) && !flush;
            assign o_tvalid = (count != '0) && !flush;
            assign push     = i_tvalid && i_tready;
            assign pop      = o_tvalid && o_tready;

            // The RAM reads at the pointer value the head will have after this edge.
            assign rd_next = flush ? '0 : (pop ? rd_ptr + SIZE'(1) : rd_ptr);

            always_ff @(posedge clk) begin
                if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + SIZE'(1);
                    end
                    rd_ptr <= rd_next;
                    if (push && !pop) begin
                        count <= count + COUNT_W'(1);
                    end else if (pop && !push) begin
                        count <= count - COUNT_W'(1);
                    end
                end
            end

            axi_fifo_param_ram #(
                .WIDTH (WIDTH),
                .SIZE  (SIZE)
            ) u_ram (
                .clk     (clk),
                .wr_en   (push),
                .wr_addr (wr_ptr),
                .wr_data (i_tdata),
                .rd_addr (rd_next),
                .rd_data (o_tdata)
            );

            assign occupied = count;
            assign space    = DEPTH_CNT - count;
        end
    endgenerate

endmodule

// File: tb/tb_axi_fifo_param.sv
// tb/tb_axi_fifo_param.sv - directed vector bench for axi_fifo_param, buffered and pass-through
module tb_axi_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clear, i_tvalid, i_tready, o_tvalid, o_tready;
    logic [31:0] i_tdata, o_tdata;
    logic [17:0] space, occupied;

    logic        p_reset, p_clear, p_i_tvalid, p_i_tready, p_o_tvalid, p_o_tready;
    logic [31:0] p_i_tdata, p_o_tdata;
    logic [17:0] p_space, p_occupied;

    axi_fifo_param #(.WIDTH(32), .SIZE(2), .PASSTHRU(1'b0)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .space    (space),
        .occupied (occupied)
    );

    axi_fifo_param #(.WIDTH(32), .SIZE(2), .PASSTHRU(1'b1)) dut_pass (
        .clk      (clk),
        .reset    (p_reset),
        .clear    (p_clear),
        .i_tdata  (p_i_tdata),
        .i_tvalid (p_i_tvalid),
        .i_tready (p_i_tready),
        .o_tdata  (p_o_tdata),
        .o_tvalid (p_o_tvalid),
        .o_tready (p_o_tready),
        .space    (p_space),
        .occupied (p_occupied)
    );

    typedef struct {
        logic        rst, clr, iv, ordy;
        logic [31:0] d;
        logic        e_it, e_ov, ck_d;
        logic [31:0] e_d;
        logic        ck_cnt;
        logic [17:0] e_occ;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic clr, input logic iv, input logic ordy,
                                input logic [31:0] d, input logic e_it, input logic e_ov,
                                input logic ck_d, input logic [31:0] e_d,
                                input logic ck_cnt, input logic [17:0] e_occ);
        vec_t v;
        v.rst = rst; v.clr = clr; v.iv = iv; v.ordy = ordy; v.d = d;
        v.e_it = e_it; v.e_ov = e_ov; v.ck_d = ck_d; v.e_d = e_d;
        v.ck_cnt = ck_cnt; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0; i_tdata = '0;
        p_reset = 1'b0; p_clear = 1'b0; p_i_tvalid = 1'b0; p_o_tready = 1'b0; p_i_tdata = '0;

        // reset held 3 cycles
        vecs.push_back(mk(1,0,0,0,32'h0,    0,0,0,32'h0,  0,0));
        vecs.push_back(mk(1,0,0,0,32'h0,    0,0,0,32'h0,  1,0));
        vecs.push_back(mk(1,0,0,0,32'h0,    0,0,0,32'h0,  1,0));
        // fill to full with o_tready low
        vecs.push_back(mk(0,0,1,0,32'hA0,   1,0,0,32'h0,  1,0));
        vecs.push_back(mk(0,0,1,0,32'hA1,   1,1,1,32'hA0, 1,1));
        vecs.push_back(mk(0,0,1,0,32'hA2,   1,1,1,32'hA0, 1,2));
        vecs.push_back(mk(0,0,1,0,32'hA3,   1,1,1,32'hA0, 1,3));
        vecs.push_back(mk(0,0,1,0,32'hA4,   0,1,1,32'hA0, 1,4));
        vecs.push_back(mk(0,0,1,0,32'hA4,   0,1,1,32'hA0, 1,4));
        // drain
        vecs.push_back(mk(0,0,0,1,32'h0,    0,1,1,32'hA0, 1,4));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,1,32'hA1, 1,3));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,1,32'hA2, 1,2));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,1,32'hA3, 1,1));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,0,0,32'h0,  1,0));
        // refill, then pop at full: no push that cycle, push on the next
        vecs.push_back(mk(0,0,1,0,32'hB0,   1,0,0,32'h0,  1,0));
        vecs.push_back(mk(0,0,1,0,32'hB1,   1,1,1,32'hB0, 1,1));
        vecs.push_back(mk(0,0,1,0,32'hB2,   1,1,1,32'hB0, 1,2));
        vecs.push_back(mk(0,0,1,0,32'hB3,   1,1,1,32'hB0, 1,3));
        vecs.push_back(mk(0,0,1,1,32'hB4,   0,1,1,32'hB0, 1,4));
        vecs.push_back(mk(0,0,1,0,32'hB4,   1,1,1,32'hB1, 1,3));
        vecs.push_back(mk(0,0,0,1,32'h0,    0,1,1,32'hB1, 1,4));
        // clear with 3 words held, handshakes attempted in the clear cycle
        vecs.push_back(mk(0,1,1,1,32'hC0,   0,0,0,32'h0,  1,3));
        vecs.push_back(mk(0,0,1,1,32'hD0,   1,0,0,32'h0,  1,0));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,1,32'hD0, 1,1));
        vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0,32'h0,  1,0));
        // reset and clear together
        vecs.push_back(mk(1,1,1,1,32'hE0,   0,0,0,32'h0,  1,0));
        vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0,32'h0,  1,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            clear    = vecs[i].clr;
            i_tvalid = vecs[i].iv;
            o_tready = vecs[i].ordy;
            i_tdata  = vecs[i].d;
            #1;
            check($sformatf("v%0d.i_tready", i), 32'(i_tready), 32'(vecs[i].e_it));
            check($sformatf("v%0d.o_tvalid", i), 32'(o_tvalid), 32'(vecs[i].e_ov));
            if (vecs[i].ck_d)
                check($sformatf("v%0d.o_tdata", i), o_tdata, vecs[i].e_d);
            if (vecs[i].ck_cnt) begin
                check($sformatf("v%0d.occupied", i), 32'(occupied), 32'(vecs[i].e_occ));
                check($sformatf("v%0d.space", i), 32'(space), 32'(18'd4 - vecs[i].e_occ));
            end
        end

        // streaming: 20 words, push and pop every cycle
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            reset    = 1'b0;
            clear    = 1'b0;
            i_tvalid = (k < 20);
            o_tready = 1'b1;
            i_tdata  = 32'h100 + 32'(k);
            #1;
            if (k == 0) begin
                check("stream.first_o_tvalid", 32'(o_tvalid), 32'd0);
                check("stream.first_occupied", 32'(occupied), 32'd0);
            end else begin
                check($sformatf("stream%0d.o_tvalid", k), 32'(o_tvalid), 32'd1);
                check($sformatf("stream%0d.o_tdata", k), o_tdata, 32'h100 + 32'(k - 1));
                check($sformatf("stream%0d.occupied", k), 32'(occupied), 32'd1);
                check($sformatf("stream%0d.i_tready", k), 32'(i_tready), 32'd1);
            end
        end
        @(negedge clk);
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        #1;
        check("stream.end_o_tvalid", 32'(o_tvalid), 32'd0);
        check("stream.end_occupied", 32'(occupied), 32'd0);

        // pass-through instance: random traffic, reset/clear ignored
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            p_i_tdata  = $urandom;
            p_i_tvalid = 1'($urandom_range(0, 1));
            p_o_tready = 1'($urandom_range(0, 1));
            p_reset    = 1'($urandom_range(0, 1));
            p_clear    = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("pass%0d.o_tdata", k), p_o_tdata, p_i_tdata);
            check($sformatf("pass%0d.o_tvalid", k), 32'(p_o_tvalid), 32'(p_i_tvalid));
            check($sformatf("pass%0d.i_tready", k), 32'(p_i_tready), 32'(p_o_tready));
            check($sformatf("pass%0d.space", k), 32'(p_space), 32'd4);
            check($sformatf("pass%0d.occupied", k), 32'(p_occupied), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
